// File: rtl/adc_edge_trigger.sv
// adc_edge_trigger: edge trigger for an 8-lane ADC word stream with hysteresis,
// holdoff and single-shot or auto re-arm.
//
// Ports
//   divclk          in   ADC word clock; all logic on the rising edge
//   rst             in   synchronous active-high reset
//   adc_data[63:0]  in   8 signed samples, lane i = [8i+7:8i], lane 0 oldest
//   data_valid      in   adc_data valid this cycle
//   trig_level[7:0] in   signed threshold
//   trig_hyst[7:0]  in   unsigned hysteresis
//   trig_falling    in   0 = rising edge, 1 = falling edge
//   trig_auto       in   0 = single-shot, 1 = auto re-arm after holdoff
//   holdoff         in   post-trigger dead time in valid words
//   arm, disarm     in   single-cycle commands (disarm wins)
//   data_out[63:0]  out  adc_data delayed one cycle
//   data_out_valid  out  data_valid delayed one cycle
//   trig_pulse      out  one-cycle strobe aligned with the word in data_out
//   trig_lane[2:0]  out  lane of the trigger sample, held until next trigger
//   armed           out  high while priming or armed
//   trig_count      out  saturating trigger count since reset
module adc_edge_trigger #(
    parameter int unsigned HOLDOFF_W = 16
) (
    input  logic                 divclk,
    input  logic                 rst,
    input  logic [63:0]          adc_data,
    input  logic                 data_valid,
    input  logic signed [7:0]    trig_level,
    input  logic [7:0]           trig_hyst,
    input  logic                 trig_falling,
    input  logic                 trig_auto,
    input  logic [HOLDOFF_W-1:0] holdoff,
    input  logic                 arm,
    input  logic                 disarm,
    output logic [63:0]          data_out,
    output logic                 data_out_valid,
    output logic                 trig_pulse,
    output logic [2:0]           trig_lane,
    output logic                 armed,
    output logic [31:0]          trig_count
);

    typedef enum logic [1:0] {StIdle, StPrime, StArmed, StHoldoff} state_e;

    state_e               state_q, state_d;
    logic                 primed_q, primed_d;
    logic [HOLDOFF_W-1:0] hold_q, hold_d;
    logic [63:0]          data_q;
    logic                 dv_q;
    logic                 pulse_q, pulse_d;
    logic [2:0]           lane_q, lane_d;
    logic [31:0]          count_q, count_d;

    // Thresholds are formed 10 bits wide so level +/- hyst cannot wrap before
    // being clamped back into the 8-bit sample range.
    logic signed [9:0] level_w, hyst_w, lo_wide, hi_wide;
    logic signed [7:0] lo, hi;

    always_comb begin
        level_w = {{2{trig_level[7]}}, trig_level};
        hyst_w  = {2'b00, trig_hyst};
        lo_wide = level_w - hyst_w;
        hi_wide = level_w + hyst_w;
        lo      = (lo_wide < -10'sd128) ? -8'sd128 : lo_wide[7:0];
        hi      = (hi_wide > 10'sd127)  ? 8'sd127  : hi_wide[7:0];
    end

    // Walk the lanes oldest first. A lane may only fire if an earlier lane
    // (or an earlier word) primed; the priming lane itself cannot fire.
    logic       fire;
    logic [2:0] fire_lane;
    logic       primed_w;

    always_comb begin
        logic signed [7:0] s;
        logic              prime_c, fire_c;
        fire      = 1'b0;
        fire_lane = 3'd0;
        primed_w  = primed_q;
        s         = '0;
        prime_c   = 1'b0;
        fire_c    = 1'b0;
        for (int i = 0; i < 8; i++) begin
            s       = adc_data[8*i +: 8];
            prime_c = trig_falling ? (s >= hi) : (s <= lo);
            fire_c  = trig_falling ? (s <= trig_level) : (s >= trig_level);
            if (!fire) begin
                if (primed_w && fire_c) begin
                    fire      = 1'b1;
                    fire_lane = 3'(i);
                end else if (prime_c) begin
                    primed_w = 1'b1;
                end
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        primed_d = primed_q;
        hold_d   = hold_q;
        pulse_d  = 1'b0;
        lane_d   = lane_q;
        count_d  = count_q;

        unique case (state_q)
            StIdle: begin
                if (arm) begin
                    state_d  = StPrime;
                    primed_d = 1'b0;
                end
            end
            StPrime, StArmed: begin
                if (data_valid) begin
                    if (fire) begin
                        pulse_d  = 1'b1;
                        lane_d   = fire_lane;
                        count_d  = (count_q == 32'hFFFF_FFFF) ? count_q : count_q + 32'd1;
                        state_d  = StHoldoff;
                        hold_d   = holdoff;
                        primed_d = 1'b0;
                    end else begin
                        primed_d = primed_w;
                        if (primed_w) begin
                            state_d = StArmed;
                        end
                    end
                end
            end
            StHoldoff: begin
                if (data_valid) begin
                    if (hold_q == '0) begin
                        state_d  = trig_auto ? StPrime : StIdle;
                        primed_d = 1'b0;
                    end else begin
                        hold_d = hold_q - HOLDOFF_W'(1);
                    end
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // Disarm overrides everything, including a fire in the same word.
        if (disarm) begin
            state_d  = StIdle;
            primed_d = 1'b0;
            hold_d   = '0;
            pulse_d  = 1'b0;
            lane_d   = lane_q;
            count_d  = count_q;
        end
    end

    always_ff @(posedge divclk) begin
        if (rst) begin
            state_q  <= StIdle;
            primed_q <= 1'b0;
            hold_q   <= '0;
            data_q   <= '0;
            dv_q     <= 1'b0;
            pulse_q  <= 1'b0;
            lane_q   <= 3'd0;
            count_q  <= 32'd0;
        end else begin
            state_q  <= state_d;
            primed_q <= primed_d;
            hold_q   <= hold_d;
            data_q   <= adc_data;
            dv_q     <= data_valid;
            pulse_q  <= pulse_d;
            lane_q   <= lane_d;
            count_q  <= count_d;
        end
    end

    assign data_out       = data_q;
    assign data_out_valid = dv_q;
    assign trig_pulse     = pulse_q;
    assign trig_lane      = lane_q;
    assign armed          = (state_q == StPrime) || (state_q == StArmed);
    assign trig_count     = count_q;

endmodule

// File: tb/tb_adc_edge_trigger.sv
// Directed self-checking bench for adc_edge_trigger.
module tb_adc_edge_trigger;

    logic               divclk;
    logic               rst;
    logic [63:0]        adc_data;
    logic               data_valid;
    logic signed [7:0]  trig_level;
    logic [7:0]         trig_hyst;
    logic               trig_falling;
    logic               trig_auto;
    logic [15:0]        holdoff;
    logic               arm;
    logic               disarm;
    logic [63:0]        data_out;
    logic               data_out_valid;
    logic               trig_pulse;
    logic [2:0]         trig_lane;
    logic               armed;
    logic [31:0]        trig_count;

    int checks = 0;
    int errors = 0;
    int exp_count = 0;

    adc_edge_trigger #(.HOLDOFF_W(16)) dut (
        .divclk         (divclk),
        .rst            (rst),
        .adc_data       (adc_data),
        .data_valid     (data_valid),
        .trig_level     (trig_level),
        .trig_hyst      (trig_hyst),
        .trig_falling   (trig_falling),
        .trig_auto      (trig_auto),
        .holdoff        (holdoff),
        .arm            (arm),
        .disarm         (disarm),
        .data_out       (data_out),
        .data_out_valid (data_out_valid),
        .trig_pulse     (trig_pulse),
        .trig_lane      (trig_lane),
        .armed          (armed),
        .trig_count     (trig_count)
    );

    initial divclk = 1'b0;
    always #5 divclk = ~divclk;

    function automatic logic [63:0] w8(input int a0, input int a1, input int a2, input int a3,
                                       input int a4, input int a5, input int a6, input int a7);
        logic [63:0] w;
        w[7:0]   = 8'(a0);
        w[15:8]  = 8'(a1);
        w[23:16] = 8'(a2);
        w[31:24] = 8'(a3);
        w[39:32] = 8'(a4);
        w[47:40] = 8'(a5);
        w[55:48] = 8'(a6);
        w[63:56] = 8'(a7);
        return w;
    endfunction

    task automatic tick();
        @(posedge divclk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Present one valid word and clock it in.
    task automatic word(input logic [63:0] w);
        adc_data   = w;
        data_valid = 1'b1;
        tick();
    endtask

    task automatic do_arm();
        arm        = 1'b1;
        data_valid = 1'b0;
        tick();
        arm = 1'b0;
    endtask

    logic [63:0] sq, neg, pos, wv;

    // Square-wave word j of the auto-rearm run: fire every 5th word at lane 4.
    task automatic sq_word(input int j);
        word(sq);
        if (j % 5 == 0) exp_count++;
        chk($sformatf("auto_pulse_%0d", j), trig_pulse, (j % 5 == 0));
        chk($sformatf("auto_armed_%0d", j), armed, (j % 5 == 4));
        chk($sformatf("auto_count_%0d", j), trig_count, exp_count);
        if (j % 5 == 0) chk($sformatf("auto_lane_%0d", j), trig_lane, 3'd4);
    endtask

    initial begin
        sq  = w8(-50, -50, -50, -50, 50, 50, 50, 50);
        neg = w8(-50, -50, -50, -50, -50, -50, -50, -50);
        pos = w8(50, 50, 50, 50, 50, 50, 50, 50);

        rst          = 1'b1;
        adc_data     = 64'hDEAD_BEEF_0123_4567;
        data_valid   = 1'b1;
        trig_level   = 8'sd0;
        trig_hyst    = 8'd16;
        trig_falling = 1'b0;
        trig_auto    = 1'b0;
        holdoff      = 16'd0;
        arm          = 1'b0;
        disarm       = 1'b0;
        tick();
        tick();
        chk("rst_data_out", data_out, 64'd0);
        chk("rst_dov", data_out_valid, 1'b0);
        chk("rst_pulse", trig_pulse, 1'b0);
        chk("rst_lane", trig_lane, 3'd0);
        chk("rst_armed", armed, 1'b0);
        chk("rst_count", trig_count, 32'd0);
        rst = 1'b0;

        // No detection before arm, even with a qualifying word.
        wv = w8(-20, -5, -3, 30, 5, -40, 50, 60);
        word(wv);
        chk("noarm_pulse", trig_pulse, 1'b0);
        chk("noarm_data", data_out, wv);
        chk("noarm_dov", data_out_valid, 1'b1);
        chk("noarm_armed", armed, 1'b0);

        // Rising, level 0, hyst 16: prime at lane 0 (-20 <= -16), fire at lane 3.
        // Later lanes (-40 prime, 50 fire) must be ignored in the same word.
        do_arm();
        chk("t1_armed", armed, 1'b1);
        word(wv);
        exp_count++;
        chk("t1_pulse", trig_pulse, 1'b1);
        chk("t1_lane", trig_lane, 3'd3);
        chk("t1_count", trig_count, exp_count);
        chk("t1_data", data_out, wv);
        chk("t1_armed_hold", armed, 1'b0);
        word(sq);
        chk("t1_exit_pulse", trig_pulse, 1'b0);
        word(sq);
        chk("t1_idle_pulse", trig_pulse, 1'b0);
        chk("t1_idle_count", trig_count, exp_count);
        chk("t1_lane_held", trig_lane, 3'd3);

        // Hysteresis: +/-10 never primes; -17 in lane 7 primes, +1 next word fires.
        do_arm();
        word(w8(-10, 10, -10, 10, -10, 10, -10, 10));
        chk("t2_osc_pulse", trig_pulse, 1'b0);
        word(w8(10, -10, 10, -10, 10, -10, 10, -10));
        chk("t2_osc2_pulse", trig_pulse, 1'b0);
        chk("t2_osc_armed", armed, 1'b1);
        word(w8(-10, 10, -10, 10, -10, 10, -10, -17));
        chk("t2_prime_pulse", trig_pulse, 1'b0);
        chk("t2_prime_armed", armed, 1'b1);
        word(w8(1, -10, 10, -10, 10, -10, 10, -10));
        exp_count++;
        chk("t2_pulse", trig_pulse, 1'b1);
        chk("t2_lane", trig_lane, 3'd0);
        chk("t2_count", trig_count, exp_count);
        word(64'd0);

        // Falling, level -128, hyst 10: hi = -118; fire only on -128.
        trig_falling = 1'b1;
        trig_level   = 8'sh80;
        trig_hyst    = 8'd10;
        do_arm();
        word(w8(-120, -128, -119, -128, -128, -128, -128, -128));
        chk("t3_noprime_pulse", trig_pulse, 1'b0);
        word(w8(-120, -119, -118, -128, 0, 0, 0, 0));
        exp_count++;
        chk("t3_pulse", trig_pulse, 1'b1);
        chk("t3_lane", trig_lane, 3'd3);
        word(64'd0);

        // Falling, level 127, hyst 200: hi clamps to 127 (a wrapped hi of 71
        // would prime on 100 and fire at lane 1).
        trig_level = 8'sh7F;
        trig_hyst  = 8'd200;
        do_arm();
        word(w8(100, 80, 127, 50, 0, 0, 0, 0));
        exp_count++;
        chk("t3_hisat_pulse", trig_pulse, 1'b1);
        chk("t3_hisat_lane", trig_lane, 3'd3);
        word(64'd0);

        // Rising, level -128, hyst 200: lo clamps to -128 (a wrapped lo of -72
        // would prime on -100 and fire at lane 1).
        trig_falling = 1'b0;
        trig_level   = 8'sh80;
        do_arm();
        word(w8(-100, -50, -128, 0, 0, 0, 0, 0));
        exp_count++;
        chk("t3_losat_pulse", trig_pulse, 1'b1);
        chk("t3_losat_lane", trig_lane, 3'd3);
        chk("t3_losat_count", trig_count, exp_count);
        word(64'd0);

        // Auto re-arm, holdoff 3, square wave: a trigger every 5 valid words.
        trig_level = 8'sd0;
        trig_hyst  = 8'd16;
        trig_auto  = 1'b1;
        holdoff    = 16'd3;
        do_arm();
        for (int j = 0; j <= 10; j++) sq_word(j);

        // Valid gap during holdoff: nothing moves.
        for (int g = 0; g < 4; g++) begin
            adc_data   = sq;
            data_valid = 1'b0;
            tick();
            chk($sformatf("gap_h_pulse_%0d", g), trig_pulse, 1'b0);
            chk($sformatf("gap_h_dov_%0d", g), data_out_valid, 1'b0);
        end
        for (int j = 11; j <= 19; j++) sq_word(j);

        // Enter ARMED, then a valid gap with a firing pattern and a stray arm.
        word(neg);
        chk("arm_state_pulse", trig_pulse, 1'b0);
        chk("arm_state_armed", armed, 1'b1);
        for (int g = 0; g < 4; g++) begin
            adc_data   = pos;
            data_valid = 1'b0;
            arm        = (g == 1);
            tick();
            chk($sformatf("gap_a_pulse_%0d", g), trig_pulse, 1'b0);
            chk($sformatf("gap_a_armed_%0d", g), armed, 1'b1);
        end
        arm = 1'b0;
        word(pos);
        exp_count++;
        chk("gap_a_fire", trig_pulse, 1'b1);
        chk("gap_a_lane", trig_lane, 3'd0);
        chk("gap_a_count", trig_count, exp_count);

        // Disarm mid-holdoff returns to idle.
        disarm = 1'b1;
        word(sq);
        disarm = 1'b0;
        chk("dis_armed", armed, 1'b0);
        chk("dis_pulse", trig_pulse, 1'b0);
        word(sq);
        chk("dis_idle_pulse", trig_pulse, 1'b0);

        // Arm and disarm together: stays idle.
        arm    = 1'b1;
        disarm = 1'b1;
        data_valid = 1'b0;
        tick();
        arm    = 1'b0;
        disarm = 1'b0;
        chk("armdis_armed", armed, 1'b0);
        word(sq);
        chk("armdis_pulse", trig_pulse, 1'b0);
        chk("armdis_count", trig_count, exp_count);

        // Fire again, then reset in holdoff clears everything.
        do_arm();
        word(sq);
        exp_count++;
        chk("pre_rst_pulse", trig_pulse, 1'b1);
        chk("pre_rst_count", trig_count, exp_count);
        rst        = 1'b1;
        adc_data   = sq;
        data_valid = 1'b1;
        tick();
        chk("rst2_data_out", data_out, 64'd0);
        chk("rst2_dov", data_out_valid, 1'b0);
        chk("rst2_pulse", trig_pulse, 1'b0);
        chk("rst2_lane", trig_lane, 3'd0);
        chk("rst2_armed", armed, 1'b0);
        chk("rst2_count", trig_count, 32'd0);
        rst = 1'b0;
        word(sq);
        chk("post_rst_pulse", trig_pulse, 1'b0);
        chk("post_rst_armed", armed, 1'b0);
        chk("post_rst_data", data_out, sq);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
